branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Consumes the ALU condition flags (Zero, N, V, C from an A-B subtract) plus branch/jump decode,
//  resolves taken/not-taken and the redirect target, and hands the result to fetch through a
//  registered valid/ready stage. Sits between execute and the PC-select logic of the RV32I core.
//  Also keeps saturating branch/taken counters for performance debug.
// PARAMETERS
//  CNT_W   16   width of each saturating statistics counter
// PORTS
//  clk            in   1      core clock, all state on rising edge
//  rst            in   1      asynchronous, active-low reset
//  flush          in   1      drop held result and any same-cycle input
//  in_valid       in   1      execute presents a control-flow op
//  in_ready       out  1      unit can accept (= ~out_valid | out_ready)
//  in_is_branch   in   1      conditional branch, condition from in_funct3
//  in_is_jal      in   1      JAL, always taken, target = pc+imm
//  in_is_jalr     in   1      JALR, always taken, target = (rs1+imm) & ~1
//  in_funct3      in   3      000 BEQ,001 BNE,100 BLT,101 BGE,110 BLTU,111 BGEU
//  in_zero,in_n,in_v,in_c in 1 each  ALU flags of rs1-rs2
//  in_pc          in   32     PC of the op
//  in_imm         in   32     sign-extended immediate
//  in_rs1         in   32     rs1 value (JALR base)
//  out_valid      out  1      result held for fetch
//  out_ready      in   1      fetch consumes result
//  out_taken      out  1      redirect PC to out_target
//  out_target     out  32     redirect address
//  out_link       out  32     pc+4 (rd value for JAL/JALR)
//  out_illegal    out  1      branch with funct3 010/011
//  out_misalign   out  1      taken and out_target[1:0]!=0
//  cnt_clr        in   1      synchronous clear of both counters
//  cnt_branch     out  CNT_W  completed conditional branches
//  cnt_taken      out  CNT_W  completed taken conditional branches
// BEHAVIOUR
//  Reset: out_valid=0, out_taken=0, out_target=0, out_link=0, out_illegal=0, out_misalign=0,
//   counters=0. Reset mid-transfer discards the held result; no output handshake occurs.
//  Conditions: EQ=Z; NE=~Z; LT=N^V; GE=~(N^V); LTU=~C; GEU=C (C=1 means no borrow).
//  Accept when in_valid & in_ready & ~flush: register all outputs; 1-cycle latency to out_valid.
//  Exactly one of is_branch/is_jal/is_jalr expected; priority jalr > jal > branch if several set;
//   none set -> out_taken=0, out_target=pc+4, treated as non-branch (not counted).
//  Branch target = pc+imm; not-taken branch target = pc+4. All adds mod 2^32 (wrap silently).
//  Illegal funct3: out_taken=0, out_illegal=1, target=pc+4; counted in cnt_branch, not cnt_taken.
//  out_misalign computed only when taken; not-taken results always 0.
//  Handshake: out_* stable while out_valid & ~out_ready. Accept+consume same cycle allowed
//   (back-to-back throughput 1/cycle). in_ready combinational from out_valid/out_ready only.
//  flush: next cycle out_valid=0; same-cycle input dropped. An output handshake completing in
//   the flush cycle counts as delivered and is counted.
//  Counters update on out_valid & out_ready for conditional branches only; saturate at
//   2^CNT_W-1 (no wrap). cnt_clr wins over a same-cycle increment.
// TESTING
//  BEQ rs1-rs2 flags Z=1, pc=0x100, imm=0x20 -> next cycle out_valid, taken=1, target=0x120.
//  BLT with N=1,V=1 (no overflow-corrected LT) -> taken=0, target=pc+4; BLTU C=0 -> taken=1.
//  JALR rs1=0x1003, imm=0 -> target=0x1002, misalign=1, link=pc+4; JAL pc=0xFFFFFFFC,imm=8 -> 0x4.
//  out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs stable, then drain in order.
//  flush with out_valid=1 and in_valid=1, out_ready=0 -> out_valid=0 next cycle, counters unchanged.
//  CNT_W=4: 20 taken branches -> cnt_taken=15 saturated; cnt_clr with handshake -> 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Resolves branch/jump direction and redirect target from ALU flags and decode.
// Latency: 1 cycle from accepted input to out_valid; accept and consume may overlap.
// Backpressure: in_ready = ~out_valid | out_ready; the held result stays stable while stalled.
module branch_resolve_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_branch,
    input  logic             in_is_jal,
    input  logic             in_is_jalr,
    input  logic [2:0]       in_funct3,
    input  logic             in_zero,
    input  logic             in_n,
    input  logic             in_v,
    input  logic             in_c,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_rs1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [31:0]      out_target,
    output logic [31:0]      out_link,
    output logic             out_illegal,
    output logic             out_misalign,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic        accept;
    logic        consume;
    logic        nxt_taken;
    logic [31:0] nxt_target;
    logic [31:0] nxt_link;
    logic        nxt_illegal;
    logic        nxt_misalign;
    logic        nxt_cond;
    logic        br_cond;
    logic        br_legal;
    logic        held_cond;   // held result came from a conditional branch

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready & ~flush;
    assign consume  = out_valid & out_ready;

    // Branch condition from the subtract flags; C=1 means rs1 >= rs2 unsigned.
    always_comb begin
        br_cond  = 1'b0;
        br_legal = 1'b1;
        case (in_funct3)
            3'b000:  br_cond = in_zero;
            3'b001:  br_cond = ~in_zero;
            3'b100:  br_cond = in_n ^ in_v;
            3'b101:  br_cond = ~(in_n ^ in_v);
            3'b110:  br_cond = ~in_c;
            3'b111:  br_cond = in_c;
            default: br_legal = 1'b0;
        endcase
    end

    // Resolve taken/target with priority jalr > jal > branch; anything else falls through to pc+4.
    always_comb begin
        nxt_link    = in_pc + 32'd4;
        nxt_taken   = 1'b0;
        nxt_target  = nxt_link;
        nxt_illegal = 1'b0;
        nxt_cond    = 1'b0;
        if (in_is_jalr) begin
            nxt_taken  = 1'b1;
            nxt_target = (in_rs1 + in_imm) & 32'hFFFF_FFFE;
        end else if (in_is_jal) begin
            nxt_taken  = 1'b1;
            nxt_target = in_pc + in_imm;
        end else if (in_is_branch) begin
            nxt_cond    = 1'b1;
            nxt_illegal = ~br_legal;
            if (br_legal && br_cond) begin
                nxt_taken  = 1'b1;
                nxt_target = in_pc + in_imm;
            end
        end
        nxt_misalign = nxt_taken & (nxt_target[1:0] != 2'b00);
    end

    // Output holding register: load on accept, drop on flush, release on consume.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_taken    <= 1'b0;
            out_target   <= 32'd0;
            out_link     <= 32'd0;
            out_illegal  <= 1'b0;
            out_misalign <= 1'b0;
            held_cond    <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (consume) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                out_taken    <= nxt_taken;
                out_target   <= nxt_target;
                out_link     <= nxt_link;
                out_illegal  <= nxt_illegal;
                out_misalign <= nxt_misalign;
                held_cond    <= nxt_cond;
            end
        end
    end

    // Saturating statistics on delivered conditional branches; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_branch <= '0;
            cnt_taken  <= '0;
        end else if (cnt_clr) begin
            cnt_branch <= '0;
            cnt_taken  <= '0;
        end else if (consume && held_cond) begin
            if (cnt_branch != CNT_MAX) begin
                cnt_branch <= cnt_branch + 1'b1;
            end
            if (out_taken && (cnt_taken != CNT_MAX)) begin
                cnt_taken <= cnt_taken + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomized bench for branch_resolve_unit with a result scoreboard.
// Latency: expected results queued on accept, compared while held, popped on handshake.
// Backpressure: out_ready is driven directly, including stalls with pending input.
module tb_branch_resolve_unit;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             in_is_branch;
    logic             in_is_jal;
    logic             in_is_jalr;
    logic [2:0]       in_funct3;
    logic             in_zero;
    logic             in_n;
    logic             in_v;
    logic             in_c;
    logic [31:0]      in_pc;
    logic [31:0]      in_imm;
    logic [31:0]      in_rs1;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [31:0]      out_target;
    logic [31:0]      out_link;
    logic             out_illegal;
    logic             out_misalign;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_branch;
    logic [CNT_W-1:0] cnt_taken;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic        illegal;
        logic        misalign;
        logic        is_cond;
    } exp_t;

    exp_t             sb[$];
    int               total  = 0;
    int               passed = 0;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [CNT_W-1:0] exp_cb = '0;
    logic [CNT_W-1:0] exp_ct = '0;

    branch_resolve_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_branch(in_is_branch), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
        .in_funct3(in_funct3), .in_zero(in_zero), .in_n(in_n), .in_v(in_v), .in_c(in_c),
        .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_target(out_target), .out_link(out_link), .out_illegal(out_illegal),
        .out_misalign(out_misalign), .cnt_clr(cnt_clr),
        .cnt_branch(cnt_branch), .cnt_taken(cnt_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    endtask

    // Reference: compares the real operands rather than decoding flags.
    function automatic exp_t model();
        exp_t e;
        logic t;
        e.link    = in_pc + 32'd4;
        e.taken   = 1'b0;
        e.target  = e.link;
        e.illegal = 1'b0;
        e.is_cond = 1'b0;
        t         = 1'b0;
        if (in_is_jalr) begin
            e.taken  = 1'b1;
            e.target = (in_rs1 + in_imm) & 32'hFFFF_FFFE;
        end else if (in_is_jal) begin
            e.taken  = 1'b1;
            e.target = in_pc + in_imm;
        end else if (in_is_branch) begin
            e.is_cond = 1'b1;
            case (in_funct3)
                3'd0: t = (op_a == op_b);
                3'd1: t = (op_a != op_b);
                3'd4: t = ($signed(op_a) <  $signed(op_b));
                3'd5: t = ($signed(op_a) >= $signed(op_b));
                3'd6: t = (op_a <  op_b);
                3'd7: t = (op_a >= op_b);
                default: e.illegal = 1'b1;
            endcase
            if (t) begin
                e.taken  = 1'b1;
                e.target = in_pc + in_imm;
            end
        end
        e.misalign = e.taken && (e.target[1:0] != 2'b00);
        return e;
    endfunction

    task automatic drive(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1);
        logic [31:0] d;
        d            = a - b;
        in_valid     = 1'b1;
        in_is_branch = br;
        in_is_jal    = jal;
        in_is_jalr   = jalr;
        in_funct3    = f3;
        in_zero      = (d == 32'd0);
        in_n         = d[31];
        in_v         = (a[31] != b[31]) && (d[31] != a[31]);
        in_c         = (a >= b);
        in_pc        = pc;
        in_imm       = imm;
        in_rs1       = rs1;
        op_a         = a;
        op_b         = b;
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        in_is_branch = 1'b0;
        in_is_jal    = 1'b0;
        in_is_jalr   = 1'b0;
    endtask

    // One clock: check at negedge against the scoreboard, then advance models.
    task automatic cycle();
        exp_t h;
        logic hs;
        logic rdy;
        @(negedge clk);
        rdy = (sb.size() == 0) || out_ready;
        chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        chk("cnt_branch", {28'd0, cnt_branch}, {28'd0, exp_cb});
        chk("cnt_taken", {28'd0, cnt_taken}, {28'd0, exp_ct});
        hs = 1'b0;
        h  = '0;
        if (sb.size() != 0) begin
            h = sb[0];
            chk("out_taken", {31'd0, out_taken}, {31'd0, h.taken});
            chk("out_target", out_target, h.target);
            chk("out_link", out_link, h.link);
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, h.illegal});
            chk("out_misalign", {31'd0, out_misalign}, {31'd0, h.misalign});
            if (out_ready) begin
                hs = 1'b1;
                void'(sb.pop_front());
            end
        end
        if (cnt_clr) begin
            exp_cb = '0;
            exp_ct = '0;
        end else if (hs && h.is_cond) begin
            if (exp_cb != '1) exp_cb++;
            if (h.taken && (exp_ct != '1)) exp_ct++;
        end
        if (flush) sb.delete();
        else if (in_valid && rdy) sb.push_back(model());
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        in_funct3 = '0; in_zero = 0; in_n = 0; in_v = 0; in_c = 0;
        in_pc = '0; in_imm = '0; in_rs1 = '0; op_a = '0; op_b = '0;
        idle();
        #12;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_taken", {31'd0, out_taken}, 32'd0);
        chk("rst_target", out_target, 32'd0);
        chk("rst_link", out_link, 32'd0);
        chk("rst_flags", {30'd0, out_illegal, out_misalign}, 32'd0);
        chk("rst_cnt", {24'd0, cnt_branch, cnt_taken}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed ops, full throughput.
        out_ready = 1'b1;
        drive(1, 0, 0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 0); cycle();
        chk("beq_taken", {31'd0, out_taken}, 32'd1);
        chk("beq_target", out_target, 32'h120);
        drive(1, 0, 0, 3'd1, 32'd5, 32'd5, 32'h140, 32'h40, 0); cycle();
        drive(1, 0, 0, 3'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h180, 32'h10, 0); cycle();
        chk("blt_ovf_taken", {31'd0, out_taken}, 32'd0);
        chk("blt_ovf_target", out_target, 32'h184);
        drive(1, 0, 0, 3'd5, 32'hFFFF_FFFD, 32'd2, 32'h200, 32'h8, 0); cycle();
        drive(1, 0, 0, 3'd6, 32'd1, 32'd2, 32'h220, 32'hFFFF_FFF0, 0); cycle();
        chk("bltu_taken", {31'd0, out_taken}, 32'd1);
        chk("bltu_target", out_target, 32'h210);
        drive(1, 0, 0, 3'd7, 32'd1, 32'd2, 32'h240, 32'h8, 0); cycle();
        drive(1, 0, 0, 3'd2, 32'd1, 32'd1, 32'h260, 32'h8, 0); cycle();
        chk("illegal", {30'd0, out_illegal, out_taken}, 32'd2);
        chk("illegal_target", out_target, 32'h264);
        drive(0, 0, 1, 3'd0, 0, 0, 32'h280, 32'd0, 32'h1003); cycle();
        chk("jalr_target", out_target, 32'h1002);
        chk("jalr_misalign", {31'd0, out_misalign}, 32'd1);
        chk("jalr_link", out_link, 32'h284);
        drive(0, 1, 0, 3'd0, 0, 0, 32'hFFFF_FFFC, 32'd8, 0); cycle();
        chk("jal_wrap_target", out_target, 32'h4);
        drive(1, 1, 1, 3'd0, 0, 1, 32'h300, 32'h12, 32'h400); cycle();
        drive(0, 0, 0, 3'd0, 0, 0, 32'h320, 32'h40, 0); cycle();
        chk("none_target", out_target, 32'h324);
        idle(); cycle();

        // Stall with a new op waiting: held result must not move.
        drive(1, 0, 0, 3'd0, 7, 7, 32'h500, 32'h10, 0); cycle();
        out_ready = 1'b0;
        drive(1, 0, 0, 3'd1, 7, 8, 32'h600, 32'h20, 0);
        repeat (3) cycle();
        chk("stall_hold", out_target, 32'h510);
        out_ready = 1'b1; cycle();
        idle(); cycle(); cycle();

        // Flush while holding, with input pending and no consume.
        drive(1, 0, 0, 3'd0, 3, 3, 32'h700, 32'h8, 0); cycle();
        out_ready = 1'b0; flush = 1'b1;
        drive(1, 0, 0, 3'd0, 3, 3, 32'h800, 32'h8, 0); cycle();
        flush = 1'b0; idle(); cycle();
        chk("flush_drop", {31'd0, out_valid}, 32'd0);
        // Flush in the same cycle as a completing handshake still counts it.
        out_ready = 1'b1;
        drive(1, 0, 0, 3'd0, 3, 3, 32'h900, 32'h8, 0); cycle();
        flush = 1'b1; idle(); cycle();
        flush = 1'b0; cycle();

        // Saturation at 15 with CNT_W=4.
        cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 3'd0, i, i, 32'h1000 + 32'(i * 4), 32'h40, 0); cycle();
        end
        idle(); cycle(); cycle();
        chk("sat_taken", {28'd0, cnt_taken}, 32'd15);
        chk("sat_branch", {28'd0, cnt_branch}, 32'd15);
        // Clear wins over a same-cycle increment.
        drive(1, 0, 0, 3'd0, 1, 1, 32'h2000, 32'h40, 0); cycle();
        cnt_clr = 1'b1; idle(); cycle();
        cnt_clr = 1'b0; cycle();
        chk("clr_wins", {24'd0, cnt_branch, cnt_taken}, 32'd0);

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        drive(1, 0, 0, 3'd0, 1, 1, 32'h3000, 32'h40, 0); cycle();
        idle();
        rst = 1'b0;
        #2;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        sb.delete(); exp_cb = '0; exp_ct = '0;
        rst = 1'b1;
        cycle();

        // Random traffic with random backpressure, flushes and clears.
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            int k;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            k = $urandom_range(0, 4);
            drive(k <= 1, k == 2, k == 3, 3'($urandom_range(0, 7)), a, b,
                  $urandom, $urandom, $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1; idle();
        cycle(); cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
